// File: rtl/mmio_pkg.sv
// mmio_pkg: shared UART state type, status bit positions and default bus addresses
package mmio_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
  localparam int ST_BUSY = 0;
  localparam int ST_FULL = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVF = 3;
  localparam int ST_CNT = 4;
  localparam logic [31:0] TXDATA_ADR_DEF = 32'h0000_00F0;
  localparam logic [31:0] STATUS_ADR_DEF = 32'h0000_00F4;
endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: byte FIFO; clk, async active-low reset, push/pop/din in, dout/full/empty/count out (push accepted when full if popping)
module byte_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic push_ok;
  assign push_ok = push && (!full || pop);
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rd];
  always_ff @(posedge clk)
    if (push_ok) mem[wr] <= din;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      wr <= wr + AW'(push_ok);
      rd <= rd + AW'(pop);
      count <= count + CW'(push_ok) - CW'(pop);
    end
endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: MMIO 8N1 UART transmitter; clk, async active-low reset, store bus (memwrite/adr/writedata) in, status readdata, tx line, busy out
module mmio_uart_tx
  import mmio_pkg::*;
#(
  parameter logic [31:0] TXDATA_ADR = TXDATA_ADR_DEF,
  parameter logic [31:0] STATUS_ADR = STATUS_ADR_DEF,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] adr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        tx,
  output logic        busy
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  uart_state_t state, state_n;
  logic [BW-1:0] baud;
  logic [2:0] bit_idx;
  logic [7:0] shreg, dout;
  logic [CW-1:0] count;
  logic [31:0] status;
  logic full, empty, ovf, pop, push_req, clr_req, baud_end, unused;
  assign push_req = memwrite && adr == TXDATA_ADR;
  assign clr_req = memwrite && adr == STATUS_ADR;
  assign baud_end = baud == BW'(CLKS_PER_BIT - 1);
  assign pop = !empty && (state == IDLE || (state == STOP && baud_end));
  assign tx = state == START ? 1'b0 : state == DATA ? shreg[0] : 1'b1;
  assign busy = state != IDLE || !empty;
  assign unused = ^writedata[31:8];
  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push_req),
    .pop(pop),
    .din(writedata[7:0]),
    .dout(dout),
    .full(full),
    .empty(empty),
    .count(count)
  );
  always_comb begin
    status = '0;
    status[ST_BUSY] = busy;
    status[ST_FULL] = full;
    status[ST_EMPTY] = empty;
    status[ST_OVF] = ovf;
    status[ST_CNT +: 4] = 4'(count);
    readdata = adr == STATUS_ADR ? status : '0;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (!empty) state_n = START;
      START: if (baud_end) state_n = DATA;
      DATA: if (baud_end && bit_idx == 3'd7) state_n = STOP;
      STOP: if (baud_end) begin
        if (empty) state_n = IDLE;
        else state_n = START;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      baud <= '0;
      bit_idx <= '0;
      shreg <= '0;
      ovf <= 1'b0;
    end else begin
      state <= state_n;
      baud <= (state == IDLE || baud_end) ? '0 : baud + BW'(1);
      bit_idx <= state == DATA ? bit_idx + 3'(baud_end) : '0;
      shreg <= pop ? dout : (state == DATA && baud_end) ? shreg >> 1 : shreg;
      ovf <= (push_req && full && !pop) || (ovf && !clr_req);
    end
endmodule
